addsub_serial: RTL and testbench
================================

# addsub_serial

Parametrised, digit-serial two's-complement adder/subtractor with valid/ready handshakes and a registered result with status flags. Each operation processes DIGIT bits per clock and takes WIDTH/DIGIT cycles. The result is held until the consumer accepts it. The block sits between an operand source and a result consumer in datapaths where area matters more than throughput.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH; NSTEP = WIDTH/DIGIT
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand presented
- in_ready  out  1  block can accept operands
- in_sub  in  1  0 = X+Y, 1 = X−Y
- in_x  in  WIDTH  operand X
- in_y  in  WIDTH  operand Y
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_s  out  WIDTH  sum or difference, modulo 2^WIDTH
- out_cout  out  1  carry out of the MSB; for subtraction, 1 = no borrow
- out_ovf  out  1  signed overflow
- out_zero  out  1  out_s == 0
- out_neg  out  1  out_s[WIDTH-1]

## Operation
- States: IDLE, RUN, DONE.
- in_ready = (state == IDLE). This is a combinational decode of the registered state.
- out_valid = (state == DONE).
- **IDLE, on in_valid & in_ready:**
  - latch x = in_x and y = in_y ^ {WIDTH{in_sub}}
  - carry = in_sub
  - step = 0
  - go to RUN
- **RUN, each cycle:**
  - digit adder sums x[DIGIT-1:0], y[DIGIT-1:0] and carry
  - x and y shift right by DIGIT
  - the DIGIT-bit result shifts into the top of the sum register, which also shifts right by DIGIT
  - carry ← digit carry-out
  - step++
  - on the last step (step == NSTEP-1), also capture cout and ovf = carry into MSB ^ carry out of MSB; the digit adder provides the carry into its top bit; then go to DONE
- **Flags:** zero and neg are derived from the final sum register. They are registered or decoded from registered values; no combinational path from inputs.
- **DONE:** out_s and all flags stay stable. On out_ready, go to IDLE.
- **Back-pressure:** in_valid is ignored in RUN and DONE. There is no accept in the same cycle that DONE completes.
- **Subtraction:** X + ~Y + 1. out_cout = 1 when X ≥ Y unsigned.
- **Edge config, DIGIT == WIDTH:** NSTEP = 1, and RUN lasts exactly one cycle.

## Timing
- **Reset values:**
  - state = IDLE, so in_ready = 1 and out_valid = 0
  - out_s = 0; out_cout, out_ovf and out_neg = 0
  - out_zero = 1, consistent with out_s == 0
- **Reset mid-operation:** the operation is abandoned; no result is emitted. The first post-reset accept behaves normally.
- **Latency:** with the accept edge at cycle 0, out_valid is high from cycle NSTEP+1. The NSTEP RUN cycles are cycles 1..NSTEP.
- **Throughput:** with out_ready held high, one operation per NSTEP+2 cycles.
- **Handshakes:** a transfer occurs on the rising edge where valid & ready are both 1. The producer may change operands freely when in_ready = 0.

## Structure
- **Shared package `addsub_pkg`:**
  - state enum (IDLE, RUN, DONE)
  - localparam helper for NSTEP
  - flag bit-index constants (COUT, OVF, ZERO, NEG) for consumers that pack flags into a vector
- **Sub-module `digit_adder`:**
  - combinational, parameter DIGIT
  - ripple chain of single-bit full adders
  - outputs: sum[DIGIT-1:0], cout, and c_msb (carry into the top bit)
- **Top-level contents:** FSM, step counter of width $clog2(NSTEP+1), x/y/sum shift registers, carry flop, flag registers.

## Test plan
All scenarios use WIDTH=16, DIGIT=4, NSTEP=4 unless noted.
- **Add:** add 0x1234 + 0x0FED → out_s = 0x2221, cout = 0, ovf = 0, zero = 0, neg = 0. out_valid rises exactly 5 cycles after the accept edge.
- **Subtract with borrow:** sub 0x0005 − 0x0007 → 0xFFFE, cout = 0, neg = 1, ovf = 0.
- **Signed overflow:**
  - add 0x7FFF + 0x0001 → 0x8000, ovf = 1, neg = 1, cout = 0
  - sub 0x8000 − 0x0001 → 0x7FFF, ovf = 1, cout = 1
- **Wrap to zero:** add 0xFFFF + 0x0001 → 0x0000, zero = 1, cout = 1, ovf = 0.
- **Back-pressure:** hold out_ready = 0 for 6 cycles in DONE → out_s and flags stable, in_ready = 0, in_valid ignored. Release → IDLE next cycle; the next operation is correct.
- **Reset and single-step config:**
  - assert rst during RUN at step 2 → out_valid = 0 and in_ready = 1 immediately; the next operation is correct
  - rerun the add scenario with DIGIT = 16 → 1-cycle RUN, identical results

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
// Consumers that pack the status flags into a vector use the bit indices below.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int COUT   = 0;
  localparam int OVF    = 1;
  localparam int ZERO   = 2;
  localparam int NEG    = 3;
  localparam int NFLAGS = 4;

  function automatic int nstep(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic logic [NFLAGS-1:0] pack_flags(input logic cout, input logic ovf,
                                                   input logic zero, input logic neg);
    logic [NFLAGS-1:0] f;
    f       = '0;
    f[COUT] = cout;
    f[OVF]  = ovf;
    f[ZERO] = zero;
    f[NEG]  = neg;
    return f;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder built from single-bit full adders.
// Also exposes the carry into the top bit so the caller can form signed overflow.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  always_comb begin
    logic cc;
    sum   = '0;
    cc    = cin;
    c_msb = cin;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = cc;
      sum[i] = a[i] ^ b[i] ^ cc;
      cc     = (a[i] & b[i]) | (cc & (a[i] ^ b[i]));
    end
    cout = cc;
  end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, WIDTH/DIGIT
// cycles per operation, result and flags held in DONE until the consumer accepts.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int NSTEP = nstep(WIDTH, DIGIT);
  localparam int CNT_W = $clog2(NSTEP + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSTEP - 1);

  state_t           state;
  logic [CNT_W-1:0] step;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

  logic [DIGIT-1:0] d_sum;
  logic             d_cout;
  logic             d_cmsb;
  logic [WIDTH-1:0] sum_next;
  logic             accept;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  assign out_s    = sum_q;
  assign out_cout = cout_q;
  assign out_ovf  = ovf_q;
  assign out_zero = zero_q;
  assign out_neg  = neg_q;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (x_q[DIGIT-1:0]),
    .b     (y_q[DIGIT-1:0]),
    .cin   (carry_q),
    .sum   (d_sum),
    .cout  (d_cout),
    .c_msb (d_cmsb)
  );

  // New digit enters at the top; after NSTEP shifts the LSB digit has reached bit 0.
  assign sum_next = (sum_q >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));

  // Operand shifters and carry: loaded on accept, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_q     <= in_x;
      y_q     <= in_y ^ {WIDTH{in_sub}};
      carry_q <= in_sub;
    end else if (state == RUN) begin
      x_q     <= x_q >> DIGIT;
      y_q     <= y_q >> DIGIT;
      carry_q <= d_cout;
    end
  end

  // Control FSM, sum register and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      step   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b1;
      neg_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= RUN;
            step  <= '0;
          end
        end
        RUN: begin
          sum_q <= sum_next;
          step  <= step + CNT_W'(1);
          if (step == LAST_STEP) begin
            state  <= DONE;
            cout_q <= d_cout;
            ovf_q  <= d_cout ^ d_cmsb;
            zero_q <= (sum_next == '0);
            neg_q  <= sum_next[WIDTH-1];
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench: drives a DIGIT=4 and a DIGIT=16 instance with identical operands
// and checks latency, results, flags, back-pressure and mid-operation reset.
module tb_addsub_serial;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_sub;
  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic         out_ready;

  logic         in_ready_a, out_valid_a, cout_a, ovf_a, zero_a, neg_a;
  logic [W-1:0] s_a;
  logic         in_ready_b, out_valid_b, cout_b, ovf_b, zero_b, neg_b;
  logic [W-1:0] s_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  addsub_serial #(.WIDTH(W), .DIGIT(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_sub(in_sub),
    .in_x(in_x), .in_y(in_y), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_s(s_a), .out_cout(cout_a), .out_ovf(ovf_a), .out_zero(zero_a), .out_neg(neg_a)
  );

  addsub_serial #(.WIDTH(W), .DIGIT(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_sub(in_sub),
    .in_x(in_x), .in_y(in_y), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_s(s_b), .out_cout(cout_b), .out_ovf(ovf_b), .out_zero(zero_b), .out_neg(neg_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags_a();
    return {cout_a, ovf_a, zero_a, neg_a};
  endfunction

  function automatic logic [3:0] flags_b();
    return {cout_b, ovf_b, zero_b, neg_b};
  endfunction

  // exp_f = {cout, ovf, zero, neg}; hold = extra DONE cycles with out_ready low and junk in_valid
  task automatic run_op(input string tag, input logic sub, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp_s,
                        input logic [3:0] exp_f, input int hold);
    int cyc;
    int lat_a;
    int lat_b;
    in_x     = x;
    in_y     = y;
    in_sub   = sub;
    in_valid = 1'b1;
    check({tag, ".in_ready_a"}, 32'(in_ready_a), 32'd1);
    check({tag, ".in_ready_b"}, 32'(in_ready_b), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_x     = ~x;
    in_y     = 16'h5A5A;
    in_sub   = ~sub;
    cyc   = 1;
    lat_a = out_valid_a ? cyc : 0;
    lat_b = out_valid_b ? cyc : 0;
    while (cyc < 20 && (lat_a == 0 || lat_b == 0)) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid_a && lat_a == 0) lat_a = cyc;
      if (out_valid_b && lat_b == 0) lat_b = cyc;
    end
    check({tag, ".lat_a"}, 32'(lat_a), 32'd5);
    check({tag, ".lat_b"}, 32'(lat_b), 32'd2);
    check({tag, ".s_a"}, 32'(s_a), 32'(exp_s));
    check({tag, ".flags_a"}, 32'(flags_a()), 32'(exp_f));
    check({tag, ".s_b"}, 32'(s_b), 32'(exp_s));
    check({tag, ".flags_b"}, 32'(flags_b()), 32'(exp_f));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_x     = W'($urandom);
      in_y     = W'($urandom);
      in_sub   = h[0];
      @(posedge clk);
      #1;
      check({tag, ".hold_s"}, 32'(s_a), 32'(exp_s));
      check({tag, ".hold_flags"}, 32'(flags_a()), 32'(exp_f));
      check({tag, ".hold_in_ready"}, 32'(in_ready_a), 32'd0);
      check({tag, ".hold_out_valid"}, 32'({out_valid_a, out_valid_b}), 32'd3);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".release_valid"}, 32'({out_valid_a, out_valid_b}), 32'd0);
    check({tag, ".release_ready"}, 32'({in_ready_a, in_ready_b}), 32'd3);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sub    = 1'b0;
    in_x      = '0;
    in_y      = '0;
    out_ready = 1'b0;
    #12;
    check("rst.in_ready", 32'({in_ready_a, in_ready_b}), 32'd3);
    check("rst.out_valid", 32'({out_valid_a, out_valid_b}), 32'd0);
    check("rst.s_a", 32'(s_a), 32'd0);
    check("rst.flags_a", 32'(flags_a()), 32'b0010);
    check("rst.flags_b", 32'(flags_b()), 32'b0010);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("add",      1'b0, 16'h1234, 16'h0FED, 16'h2221, 4'b0000, 0);
    run_op("sub_brw",  1'b1, 16'h0005, 16'h0007, 16'hFFFE, 4'b0001, 0);
    run_op("sub_ok",   1'b1, 16'h0007, 16'h0005, 16'h0002, 4'b1000, 0);
    run_op("add_ovf",  1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 0);
    run_op("sub_ovf",  1'b1, 16'h8000, 16'h0001, 16'h7FFF, 4'b1100, 0);
    run_op("wrap0",    1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 0);
    run_op("sub_eq",   1'b1, 16'h1234, 16'h1234, 16'h0000, 4'b1010, 0);
    run_op("bp",       1'b0, 16'h4321, 16'h1111, 16'h5432, 4'b0000, 6);
    run_op("after_bp", 1'b0, 16'h1234, 16'h0FED, 16'h2221, 4'b0000, 0);

    // Reset while the DIGIT=4 instance is at step 2
    in_x     = 16'h1111;
    in_y     = 16'h2222;
    in_sub   = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midrst.busy", 32'(in_ready_a), 32'd0);
    rst = 1'b1;
    #1;
    check("midrst.out_valid", 32'({out_valid_a, out_valid_b}), 32'd0);
    check("midrst.in_ready", 32'({in_ready_a, in_ready_b}), 32'd3);
    check("midrst.s_a", 32'(s_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst.idle", 32'({out_valid_a, in_ready_a}), 32'b01);
    run_op("post_rst", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 4'b0001, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
